tx_serializer: RTL

Parametrised successor to the team's 8-bit TX shift buffer. It accepts parallel words through a load/ready handshake into a one-word holding register, then serialises them on dout. One bit is emitted per en strobe, with selectable bit order and idle line level. Words queued in the holding register go out back-to-back with no idle gap. It sits between the digital core and the TX line driver.

---
 rtl/tx_pkg.sv | 19 +
 rtl/tx_serializer.sv | 95 +++++++++
 2 files changed

// File: rtl/tx_pkg.sv
// Shared constants and helpers for the TX serializer.
package tx_pkg;

  typedef enum logic {
    LsbFirst = 1'b0,
    MsbFirst = 1'b1
  } bit_order_e;

  localparam bit IdleLvlDefault = 1'b0;

  // Bits needed to count 0..n-1; never less than 1 so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Parallel-to-serial TX buffer: one-word holding register feeding a shifter
// that emits one bit per en strobe, with seamless back-to-back words.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = bit'(MsbFirst),
  parameter bit          IDLE_LVL  = IdleLvlDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  input  logic              en,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CntW    = cnt_width(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              active_q, active_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] shifted;

  assign shifted = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;

    // Accept only into an empty holding register; never collides with a
    // transfer/reload, both of which require hold_valid_q=1.
    if (load && !hold_valid_q) begin
      hold_d       = din;
      hold_valid_d = 1'b1;
    end

    if (!active_q && hold_valid_q) begin
      shreg_d      = hold_q;
      cnt_d        = '0;
      active_d     = 1'b1;
      hold_valid_d = 1'b0;
    end else if (active_q && en) begin
      shreg_d = shifted;
      if (cnt_q == CntLast) begin
        done_d = 1'b1;
        if (hold_valid_q) begin
          shreg_d      = hold_q;
          cnt_d        = '0;
          hold_valid_d = 1'b0;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      active_q     <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  assign ready = !hold_valid_q;
  assign busy  = active_q | hold_valid_q;
  assign done  = done_q;
  assign dout  = active_q ? (MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0]) : IDLE_LVL;

endmodule
